// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder block: FSM encodings, LFSR constants
// and the address-width helper.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int calc_aw(input int depth);
    int aw;
    aw = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < depth) aw = i + 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the memory-access stage (master) and mem_responder (slave).
interface mem_responder_if;
  // A request (req_rd/req_wr) is taken only on an edge where the slave is idle or in its
  // response cycle; stall=1 means the request in flight is not finished, done pulses once
  // per accepted request with data_out/err valid only in that cycle.
  logic        req_rd;
  logic        req_wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output req_rd, req_wr, addr, data_in,
    input  data_out, done, stall, err
  );

  modport slave (
    input  req_rd, req_wr, addr, data_in,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/mem_resp_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per advance pulse; used to add random
// wait cycles when MEM_RESP_RAND_STALL_EN is defined.
module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_advance,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_lfsr <= LFSR_SEED;
    else if (i_advance) r_lfsr <= {r_lfsr[14:0], w_fb};
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle 16-bit data-memory responder with IDLE/WAIT/RESP FSM.
// Optional random extra latency is enabled by defining MEM_RESP_RAND_STALL_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output state_t           o_dbg_state
);

  localparam int AW = calc_aw(DEPTH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_cnt;
  logic            r_wr;
  logic            r_err;
  logic [AW-1:0]   r_idx;
  logic [15:0]     r_data;
  logic [15:0]     r_mem [DEPTH];
  logic            w_accept;
  logic [4:0]      w_lat;

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_RESP)) &&
                    (bus.req_rd || bus.req_wr);

`ifdef MEM_RESP_RAND_STALL_EN
  logic [15:0] w_lfsr;

  mem_resp_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_accept),
    .o_lfsr    (w_lfsr)
  );

  // Extra cycles come from the LFSR value before this accept advances it.
  assign w_lat = 5'(LATENCY) + {3'b000, w_lfsr[1:0]};
`else
  assign w_lat = 5'(LATENCY);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (w_lat == 5'd1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 5'd1) w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_accept) w_state_nxt = (w_lat == 5'd1) ? ST_RESP : ST_WAIT;
        else          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The counter leaves WAIT on the edge where it decrements to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_wr   <= 1'b0;
      r_err  <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_cnt  <= w_lat - 5'd1;
      r_wr   <= bus.req_wr;
      r_err  <= bus.addr[0] | (bus.req_rd & bus.req_wr);
      r_idx  <= bus.addr[AW:1];
      r_data <= bus.data_in;
    end else if (r_state == ST_WAIT) begin
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == ST_RESP) && r_wr && !r_err) r_mem[r_idx] <= r_data;
  end

  assign bus.done     = (r_state == ST_RESP);
  assign bus.stall    = (r_state == ST_WAIT);
  assign bus.err      = (r_state == ST_RESP) && r_err;
  assign bus.data_out = ((r_state == ST_RESP) && !r_wr && !r_err) ? r_mem[r_idx] : 16'h0000;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH=256, LATENCY=2).
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int LAT = 2;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_checks;
  int     n_errors;
  int     exp_lat;
  logic [15:0] model_lfsr;

  mem_responder_if bus();

  mem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_data"}, 32'(bus.data_out), 32'd0);
  endtask

  // Reference latency model: fixed, or fixed plus low LFSR bits before it steps.
  task automatic model_accept();
`ifdef MEM_RESP_RAND_STALL_EN
    exp_lat    = LAT + int'(model_lfsr[1:0]);
    model_lfsr = {model_lfsr[14:0], ^(model_lfsr & 16'hB400)};
`else
    exp_lat = LAT;
`endif
  endtask

  // driver: called at a negedge; request is accepted on the following posedge
  task automatic start_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d);
    bus.req_rd  = rd;
    bus.req_wr  = wr;
    bus.addr    = a;
    bus.data_in = d;
    model_accept();
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
  endtask

  // returns at the negedge where done is high
  task automatic finish_txn(input string tag, input logic exp_err, input logic [15:0] exp_data);
    int cycles;
    int stalls;
    cycles = 0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cycles++;
      if (bus.done) break;
      if (bus.stall) stalls++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
    check({tag, "_stall_at_done"}, 32'(bus.stall), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic exp_err, input logic [15:0] exp_data);
    start_txn(rd, wr, a, d);
    finish_txn(tag, exp_err, exp_data);
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_lat     = LAT;
    model_lfsr  = 16'hACE1;
    rst         = 1'b0;
    bus.req_rd  = 1'b0;
    bus.req_wr  = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;

    // 1. reset and idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("rst");
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("idle");
    end

    // 2. write then read
    txn("wr10", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    txn("rd10", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);

    // 3. back-to-back: read presented in the write's response cycle
    start_txn(1'b0, 1'b1, 16'h0020, 16'h1234);
    finish_txn("b2b_wr", 1'b0, 16'h0000);
    start_txn(1'b1, 1'b0, 16'h0020, 16'h0000);
    finish_txn("b2b_rd", 1'b0, 16'h1234);
    @(negedge clk);
    check_quiet("b2b_after");

    // 4. errors
    txn("rd_odd", 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000);
    txn("wr04", 1'b0, 1'b1, 16'h0004, 16'h7777, 1'b0, 16'h0000);
    txn("rdwr04", 1'b1, 1'b1, 16'h0004, 16'h9999, 1'b1, 16'h0000);
    txn("rd04", 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h7777);
    txn("wr_odd", 1'b0, 1'b1, 16'h0005, 16'h4242, 1'b1, 16'h0000);
    txn("rd04b", 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h7777);

    // 5. address wrap
    txn("wr202", 1'b0, 1'b1, 16'h0202, 16'hA5A5, 1'b0, 16'h0000);
    txn("rd002", 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hA5A5);

    // 6. reset during WAIT drops the write
    txn("wr30", 1'b0, 1'b1, 16'h0030, 16'h1111, 1'b0, 16'h0000);
    start_txn(1'b0, 1'b1, 16'h0030, 16'h5555);
    @(negedge clk);
    check("mid_stall", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    #1;
    check_quiet("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("mid_hold");
    end
    rst        = 1'b1;
    model_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_quiet("mid_after");
    end
    txn("rd30", 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h1111);

    // repeated reads: latency tracks the model in either build
    for (int i = 0; i < 20; i++) begin
      txn($sformatf("rep%0d", i), 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
